// File: rtl/dct_pkg.sv
// Shared definitions for the 2D DCT-II sequencer.
// Contents:
//   - size encoding constants SZ_4..SZ_32 (same code as the core N input)
//   - pts_f(): transform size code -> number of points
//   - sched_state_t: sequencer state encoding
//   - lane helpers for the 32 x 16-bit packed vectors (lane 0 in bits [15:0])
package dct_pkg;

    localparam int LANE_W = 16;
    localparam int LANES  = 32;
    localparam int VEC_W  = LANE_W * LANES;

    localparam logic [1:0] SZ_4  = 2'b00;
    localparam logic [1:0] SZ_8  = 2'b01;
    localparam logic [1:0] SZ_16 = 2'b10;
    localparam logic [1:0] SZ_32 = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROW  = 2'd1,
        ST_WAIT = 2'd2,
        ST_COL  = 2'd3
    } sched_state_t;

    function automatic logic [5:0] pts_f(input logic [1:0] size);
        logic [5:0] pts;
        case (size)
            SZ_4:    pts = 6'd4;
            SZ_8:    pts = 6'd8;
            SZ_16:   pts = 6'd16;
            SZ_32:   pts = 6'd32;
            default: pts = 6'd4;
        endcase
        return pts;
    endfunction

    function automatic logic [LANE_W-1:0] lane_get(input logic [VEC_W-1:0] vec, input int idx);
        return vec[idx*LANE_W +: LANE_W];
    endfunction

    function automatic logic [VEC_W-1:0] lane_set(input logic [VEC_W-1:0] vec, input int idx,
                                                  input logic [LANE_W-1:0] val);
        logic [VEC_W-1:0] res;
        res = vec;
        res[idx*LANE_W +: LANE_W] = val;
        return res;
    endfunction

    // Keep lanes 0..pts-1, force the rest to zero.
    function automatic logic [VEC_W-1:0] mask_lanes(input logic [VEC_W-1:0] vec, input logic [5:0] pts);
        logic [VEC_W-1:0] res;
        res = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(pts)) begin
                res = lane_set(res, i, lane_get(vec, i));
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/transpose_buf.sv
// 32x32x16 transpose buffer between the row and column passes.
// Ports:
//   clk      - clock
//   wr_en    - write one column this cycle
//   wr_col   - column index (the input row number)
//   wr_data  - 32 lanes; lane k lands in mem[k][wr_col]
//   rd_row   - row index to read (coefficient index of the row pass)
//   rd_data  - full row mem[rd_row], lane c = mem[rd_row][c]
// The array carries no reset: stale entries are masked by the reader.
module transpose_buf
    import dct_pkg::*;
(
    input  logic             clk,
    input  logic             wr_en,
    input  logic [4:0]       wr_col,
    input  logic [VEC_W-1:0] wr_data,
    input  logic [4:0]       rd_row,
    output logic [VEC_W-1:0] rd_data
);

    logic [LANE_W-1:0] mem_r [LANES][LANES];

    // Lane-wise column write: coefficient k of the current row goes to row k.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < LANES; k++) begin
                mem_r[k][wr_col] <= lane_get(wr_data, k);
            end
        end
    end

    // Full-row read, packed lane c = column c.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < LANES; c++) begin
            rd_data = lane_set(rd_data, c, mem_r[rd_row][c]);
        end
    end

endmodule

// File: rtl/dct2_2d_sched.sv
// 2D DCT-II sequencer (4x4 .. 32x32) around a shared combinational 1D core.
// Row pass: each accepted row drives core_x; the core result comes back on
// core_y one cycle later and is written transposed into the buffer. Column
// pass: buffer rows are fed back through the core and the results are
// presented on out_col with a valid/ready handshake.
// Ports:
//   clk, rst_n          - clock, synchronous active-low reset
//   size                - 00=4, 01=8, 10=16, 11=32; sampled on the row-0 handshake
//   in_valid/in_ready   - row stream handshake, in_row = 32 lanes x 16 b
//   out_valid/out_ready - column result handshake, out_col lane k = coeff k
//   core_x, core_n      - registered drive of the 1D core
//   core_y              - 1D core result
//   busy                - block in progress
module dct2_2d_sched
    import dct_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int MAX_PTS = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [1:0]                  size,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [MAX_PTS*DATA_W-1:0]   in_row,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [MAX_PTS*DATA_W-1:0]   out_col,
    output logic [MAX_PTS*DATA_W-1:0]   core_x,
    output logic [1:0]                  core_n,
    input  logic [MAX_PTS*DATA_W-1:0]   core_y,
    output logic                        busy
);

    sched_state_t       state_r;
    sched_state_t       state_next_s;
    logic [1:0]         size_q_r;
    logic [5:0]         pts_s;
    logic [5:0]         row_cnt_r;
    logic [4:0]         row_wr_r;
    logic [5:0]         col_cnt_r;
    logic               pend_r;
    logic               cpend_r;
    logic [VEC_W-1:0]   core_x_r;
    logic [1:0]         core_n_r;
    logic [VEC_W-1:0]   out_col_r;
    logic               out_valid_r;
    logic [VEC_W-1:0]   buf_rd_s;

    logic               in_ready_s;
    logic               busy_s;
    logic               in_hs_s;
    logic               out_hs_s;
    logic               capture_s;
    logic               issue_s;
    logic               done_s;

    assign pts_s = pts_f(size_q_r);

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (in_hs_s) state_next_s = ST_ROW;
                else         state_next_s = ST_IDLE;
            end
            ST_ROW: begin
                if (in_hs_s && (row_cnt_r == pts_s - 6'd1)) state_next_s = ST_WAIT;
                else                                        state_next_s = ST_ROW;
            end
            ST_WAIT: state_next_s = ST_COL;
            ST_COL: begin
                if (done_s) state_next_s = ST_IDLE;
                else        state_next_s = ST_COL;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Output / handshake decode from the current state.
    always_comb begin
        in_ready_s = 1'b0;
        busy_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                in_ready_s = rst_n;
                busy_s     = 1'b0;
            end
            ST_ROW: begin
                in_ready_s = rst_n & (row_cnt_r < pts_s);
            end
            ST_WAIT: begin
                in_ready_s = 1'b0;
            end
            ST_COL: begin
                in_ready_s = 1'b0;
            end
            default: begin
                in_ready_s = 1'b0;
                busy_s     = 1'b0;
            end
        endcase
        in_hs_s   = in_valid & in_ready_s;
        out_hs_s  = out_valid_r & out_ready;
        // A pending column result is captured whenever the output slot is free
        // or being emptied this cycle; the next column may only be issued once
        // the current one has been (or is being) captured.
        capture_s = (state_r == ST_COL) & cpend_r & (~out_valid_r | out_ready);
        issue_s   = (state_r == ST_COL) & (col_cnt_r < pts_s) & (~cpend_r | capture_s);
        done_s    = (state_r == ST_COL) & out_hs_s & ~cpend_r & (col_cnt_r == pts_s);
    end

    // Datapath: core drive, counters, buffer write pointer and output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            size_q_r    <= SZ_4;
            row_cnt_r   <= 6'd0;
            row_wr_r    <= 5'd0;
            col_cnt_r   <= 6'd0;
            pend_r      <= 1'b0;
            cpend_r     <= 1'b0;
            core_x_r    <= '0;
            core_n_r    <= SZ_4;
            out_col_r   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            // core_y holds the previous row's result exactly one cycle after the row was taken.
            pend_r <= in_hs_s;
            if (state_r == ST_IDLE) begin
                row_wr_r <= 5'd0;
            end else if (pend_r) begin
                row_wr_r <= row_wr_r + 5'd1;
            end else begin
                row_wr_r <= row_wr_r;
            end

            case (state_r)
                ST_IDLE: begin
                    if (in_hs_s) begin
                        size_q_r  <= size;
                        core_n_r  <= size;
                        core_x_r  <= mask_lanes(in_row, pts_f(size));
                        row_cnt_r <= 6'd1;
                        col_cnt_r <= 6'd0;
                    end
                end
                ST_ROW: begin
                    if (in_hs_s) begin
                        core_x_r  <= mask_lanes(in_row, pts_s);
                        row_cnt_r <= row_cnt_r + 6'd1;
                    end
                end
                ST_WAIT: begin
                    col_cnt_r <= 6'd0;
                end
                ST_COL: begin
                    if (issue_s) begin
                        core_x_r  <= mask_lanes(buf_rd_s, pts_s);
                        col_cnt_r <= col_cnt_r + 6'd1;
                    end
                    if (done_s) begin
                        core_n_r  <= SZ_4;
                        row_cnt_r <= 6'd0;
                    end
                end
                default: begin
                    core_n_r <= SZ_4;
                end
            endcase

            if (issue_s) begin
                cpend_r <= 1'b1;
            end else if (capture_s) begin
                cpend_r <= 1'b0;
            end

            if (capture_s) begin
                out_col_r   <= core_y;
                out_valid_r <= 1'b1;
            end else if (out_hs_s) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    transpose_buf u_buf (
        .clk     (clk),
        .wr_en   (pend_r),
        .wr_col  (row_wr_r),
        .wr_data (core_y),
        .rd_row  (col_cnt_r[4:0]),
        .rd_data (buf_rd_s)
    );

    assign in_ready  = in_ready_s;
    assign busy      = busy_s;
    assign out_valid = out_valid_r;
    assign out_col   = out_col_r;
    assign core_x    = core_x_r;
    assign core_n    = core_n_r;

endmodule

// File: tb/tb_dct2_2d_sched.sv
// Bench for dct2_2d_sched. A behavioural 1D DCT-II (64-scaled cosine
// coefficients, >>>11, truncated to 16 b) stands in for the external core,
// and the golden 2D result is rows -> transpose -> columns on plain arrays.
module tb_dct2_2d_sched;
    import dct_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [1:0]   size;
    logic         in_valid;
    logic         in_ready;
    logic [511:0] in_row;
    logic         out_valid;
    logic         out_ready;
    logic [511:0] out_col;
    logic [511:0] core_x;
    logic [1:0]   core_n;
    logic [511:0] core_y;
    logic         busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [511:0] stim [32];
    logic [511:0] exp_col [32];
    logic [511:0] got [$];
    int h0, first_valid_cyc, last_hs_cyc, idle_cyc, n_bad, mask_bad;
    bit idle_seen;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [511:0] dct1d_vec(input logic [511:0] x, input int n);
        logic [511:0] y;
        longint acc;
        real a;
        int c;
        y = '0;
        for (int k = 0; k < n; k++) begin
            acc = 0;
            for (int i = 0; i < n; i++) begin
                a = 64.0 * $cos(3.14159265358979 * real'((2*i+1)*k) / (2.0 * real'(n)));
                c = (a >= 0.0) ? $rtoi(a + 0.5) : -$rtoi(0.5 - a);
                acc += longint'(c) * longint'($signed(x[i*16 +: 16]));
            end
            acc = acc >>> 11;
            y[k*16 +: 16] = acc[15:0];
        end
        return y;
    endfunction

    assign core_y = dct1d_vec(core_x, 4 << core_n);

    dct2_2d_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .size      (size),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_row    (in_row),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_col   (out_col),
        .core_x    (core_x),
        .core_n    (core_n),
        .core_y    (core_y),
        .busy      (busy)
    );

    task automatic chk(input string tag, input logic [511:0] act, input logic [511:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, expv);
        end
    endtask

    task automatic compute_ref(input int l);
        logic [511:0] z [32];
        logic [511:0] t [32];
        for (int r = 0; r < l; r++) z[r] = dct1d_vec(stim[r], l);
        for (int k = 0; k < l; k++) begin
            t[k] = '0;
            for (int r = 0; r < l; r++) t[k][r*16 +: 16] = z[r][k*16 +: 16];
        end
        for (int c = 0; c < l; c++) exp_col[c] = dct1d_vec(t[c], l);
    endtask

    task automatic fill_random(input int lo_lanes, input logic [15:0] hi_val);
        for (int r = 0; r < 32; r++) begin
            for (int l = 0; l < 32; l++) begin
                stim[r][l*16 +: 16] = (l < lo_lanes) ? 16'($urandom) : hi_val;
            end
        end
    endtask

    task automatic send_block(input logic [1:0] sz, input int l, input bit gappy,
                              input bit chg_size, input bit chk_mask);
        int r = 0;
        int guard = 0;
        n_bad = 0;
        mask_bad = 0;
        while (r < l && guard < 2000) begin
            @(negedge clk);
            guard++;
            if (busy && core_n != sz) n_bad++;
            if (chk_mask && r > 0 && core_x[511:256] != 256'd0) mask_bad++;
            size = (chg_size && r > 0) ? SZ_32 : sz;
            if (gappy && r > 0 && $urandom_range(0, 1) == 0) begin
                in_valid = 1'b0;
                continue;
            end
            in_valid = 1'b1;
            in_row = stim[r];
            if (in_ready) begin
                if (r == 0) h0 = cyc;
                r++;
            end
        end
        chk("send_done", 512'(r), 512'(l));
    endtask

    task automatic collect(input logic [1:0] sz, input int stall_start, input int stall_len);
        int guard = 0;
        int stall_ctr = 0;
        bit stalled_prev = 1'b0;
        logic [511:0] held;
        got.delete();
        first_valid_cyc = -1;
        last_hs_cyc = -1;
        idle_seen = 1'b0;
        held = '0;
        while (guard < 600) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            if (!busy) begin
                idle_cyc = cyc;
                idle_seen = 1'b1;
                break;
            end
            if (core_n != sz) n_bad++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (stalled_prev) begin
                chk("stall_hold", out_col, held);
                chk("stall_valid", 512'(out_valid), 512'd1);
            end
            if (stall_ctr < stall_len && got.size() == stall_start && out_valid) begin
                out_ready = 1'b0;
                held = out_col;
                stalled_prev = 1'b1;
                stall_ctr++;
            end else begin
                stalled_prev = 1'b0;
                out_ready = 1'b1;
                if (out_valid) begin
                    got.push_back(out_col);
                    last_hs_cyc = cyc;
                end
            end
        end
        out_ready = 1'b1;
        chk("idle_reached", 512'(idle_seen), 512'd1);
    endtask

    task automatic check_cols(input string name, input int l);
        chk({name, "_ncol"}, 512'(got.size()), 512'(l));
        for (int c = 0; c < l && c < got.size(); c++) begin
            chk($sformatf("%s_col%0d", name, c), got[c], exp_col[c]);
        end
    endtask

    initial begin
        int seen;
        int guard;
        rst_n = 1'b0;
        size = SZ_4;
        in_valid = 1'b0;
        in_row = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready", 512'(in_ready), 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_out_valid", 512'(out_valid), 512'd0);
        chk("rst_core_x", core_x, 512'd0);
        chk("rst_core_n", 512'(core_n), 512'd0);
        chk("rst_out_col", out_col, 512'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 512'(in_ready), 512'd1);

        // Size 4, constant 64 rows: DC = ((4*64*64)>>11 = 8, then (4*8*64)>>11 = 1).
        for (int r = 0; r < 32; r++) begin
            stim[r] = '0;
            for (int l = 0; l < 4; l++) stim[r][l*16 +: 16] = 16'd64;
        end
        compute_ref(4);
        send_block(SZ_4, 4, 1'b0, 1'b0, 1'b0);
        collect(SZ_4, -1, 0);
        check_cols("dc4", 4);
        if (got.size() > 0) chk("dc4_golden", got[0], 512'd1);
        chk("dc4_first_valid", 512'(first_valid_cyc - h0), 512'd7);
        chk("dc4_idle", 512'(idle_cyc - h0), 512'd11);
        chk("dc4_core_n", 512'(n_bad), 512'd0);

        // Size 32 random full-range.
        fill_random(32, 16'd0);
        compute_ref(32);
        send_block(SZ_32, 32, 1'b0, 1'b0, 1'b0);
        collect(SZ_32, -1, 0);
        check_cols("r32", 32);
        chk("r32_last_col", 512'(last_hs_cyc - h0), 512'd66);
        chk("r32_idle", 512'(idle_cyc - h0), 512'd67);

        // Size 8 with input gaps and a 5-cycle output stall.
        fill_random(32, 16'd0);
        compute_ref(8);
        send_block(SZ_8, 8, 1'b1, 1'b0, 1'b0);
        collect(SZ_8, 3, 5);
        check_cols("stall8", 8);

        // Size input changes to 11 after row 0: block stays 8-point.
        fill_random(32, 16'd0);
        compute_ref(8);
        send_block(SZ_8, 8, 1'b0, 1'b1, 1'b0);
        collect(SZ_8, -1, 0);
        check_cols("chg8", 8);
        chk("chg8_core_n", 512'(n_bad), 512'd0);

        // Size 16 with lanes 16..31 driven 0x7FFF.
        fill_random(16, 16'h7FFF);
        compute_ref(16);
        send_block(SZ_16, 16, 1'b0, 1'b0, 1'b1);
        chk("mask16_core_x", 512'(mask_bad), 512'd0);
        collect(SZ_16, -1, 0);
        check_cols("mask16", 16);

        // Reset during the column pass of a 16-point block.
        fill_random(32, 16'd0);
        send_block(SZ_16, 16, 1'b0, 1'b0, 1'b0);
        seen = 0;
        guard = 0;
        while (seen < 2 && guard < 200) begin
            @(negedge clk);
            guard++;
            in_valid = 1'b0;
            out_ready = 1'b1;
            if (out_valid) seen++;
        end
        chk("rst_reach_col", 512'(seen), 512'd2);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", 512'(out_valid), 512'd0);
        chk("midrst_busy", 512'(busy), 512'd0);
        chk("midrst_in_ready", 512'(in_ready), 512'd0);
        rst_n = 1'b1;
        fill_random(32, 16'd0);
        compute_ref(4);
        send_block(SZ_4, 4, 1'b0, 1'b0, 1'b0);
        collect(SZ_4, -1, 0);
        check_cols("post_rst4", 4);
        chk("post_rst4_first_valid", 512'(first_valid_cyc - h0), 512'd7);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
